// File: rtl/seq_frame_deser.sv
// Serial frame deserializer: hunts for a sync word, then assembles
// fixed-length MSB-first payload words into a small FWFT output FIFO.
module seq_frame_deser #(
  parameter int                    WORD_WIDTH    = 8,
  parameter logic [WORD_WIDTH-1:0] SYNC_WORD     = 8'hA5,
  parameter int                    PAYLOAD_WORDS = 4,
  parameter int                    FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  locked,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int W   = WORD_WIDTH;
  localparam int BW  = (W > 2) ? $clog2(W) : 1;
  localparam int WCW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BW-1:0]  BIT_LAST  = BW'(W - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(PAYLOAD_WORDS - 1);
  localparam logic [CW-1:0]  FULL      = CW'(FIFO_DEPTH);

  typedef enum logic {HUNT, RECV} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]  hunt_cnt_q, hunt_cnt_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic           frame_start_q, frame_start_d;
  logic           frame_done_q, frame_done_d;
  logic           overflow_q, overflow_d;

  logic [W-1:0]   mem_q [FIFO_DEPTH];
  logic [W-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   out_data_q, out_data_d;

  logic [W-1:0]   shifted;
  logic           push_req;
  logic           push_ok;
  logic           pop;

  assign shifted = {shreg_q[W-2:0], d};

  // One shift register serves as hunt window and word assembler
  always_comb begin
    state_d       = state_q;
    shreg_d       = shifted;
    hunt_cnt_d    = hunt_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    push_req      = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (hunt_cnt_q != BIT_LAST) begin
          hunt_cnt_d = hunt_cnt_q + 1'b1;
        end
        if (hunt_cnt_q == BIT_LAST && shifted == SYNC_WORD) begin
          state_d       = RECV;
          bit_cnt_d     = '0;
          word_cnt_d    = '0;
          frame_start_d = 1'b1;
        end
      end
      RECV: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          push_req   = 1'b1;
          bit_cnt_d  = '0;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == WORD_LAST) begin
            state_d      = HUNT;
            hunt_cnt_d   = '0;
            shreg_d      = '0;
            word_cnt_d   = '0;
            frame_done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // A full FIFO still accepts a word when the head leaves that cycle
  always_comb begin
    pop        = (count_q != '0) && out_ready;
    push_ok    = push_req && ((count_q != FULL) || pop);
    overflow_d = overflow_q | (push_req & ~push_ok);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shifted;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_d = count_q - 1'b1;
    end
    out_data_d = out_data_q;
    if (count_d != '0) begin
      out_data_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      shreg_q       <= '0;
      hunt_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      hunt_cnt_q    <= hunt_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = (count_q != '0);
  assign locked      = (state_q == RECV);
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;

endmodule
